router_sync: RTL and testbench
==============================

// Module: router_sync
// PURPOSE
// - Sits between the router FSM/register stage and the three router_fifo output queues.
// - Latches the destination address of each packet and steers the single write strobe to one FIFO.
// - Muxes the addressed FIFO's full flag back to the FSM.
// - Presents per-port valid flags and issues a per-port soft_reset when a destination stalls too long.
// PARAMETERS
// - TIMEOUT  30  consecutive stalled cycles (vld_out=1, read_enb=0) before a soft_reset pulse
// - CNT_W    5   width of each timeout counter; must satisfy 2**CNT_W >= TIMEOUT
// PORTS
// - clock          in   1  single clock, rising-edge active
// - reset          in   1  asynchronous, active-high reset
// - detect_add     in   1  FSM header-decode strobe; qualifies data_in[1:0]
// - data_in        in   2  packet address field (header bits [1:0])
// - write_enb_reg  in   1  FSM request to write current byte
// - read_enb       in   3  per-port read enables from the downstream readers
// - empty          in   3  per-port router_fifo empty flags
// - full           in   3  per-port router_fifo full flags
// - write_enb      out  3  one-hot FIFO write enables
// - fifo_full      out  1  full flag of the currently addressed FIFO
// - vld_out        out  3  per-port data-valid (~empty)
// - soft_reset     out  3  per-port one-cycle timeout pulse, to router_fifo soft_reset
// - timeout_status out  3  sticky timeout flags; present only with ROUTER_SYNC_STICKY_STATUS_EN
// - status_clr     in   1  clears timeout_status; present only with ROUTER_SYNC_STICKY_STATUS_EN
// BEHAVIOUR
// - Reset values (async, reset=1):
//   - addr_reg = 2'b11 (no port).
//   - All counters = 0.
//   - soft_reset = 3'b000.
//   - timeout_status = 3'b000.
// - Address latch:
//   - At a rising edge with detect_add=1: addr_reg <= data_in.
//   - Otherwise addr_reg holds.
//   - data_in=2'b11 is an invalid port: it is latched, and no FIFO is then selected.
// - write_enb (combinational from addr_reg):
//   - write_enb_reg=0 -> 3'b000.
//   - Otherwise 00 -> 001, 01 -> 010, 10 -> 100, 11 -> 000.
//   - Zero latency from addr_reg: the header byte is written the cycle after detect_add.
// - fifo_full (combinational):
//   - Equals full[addr_reg] for addr_reg 0..2.
//   - 0 when addr_reg=11.
// - vld_out[i] = ~empty[i] (combinational, no latency).
// - Timeout counter per port i, updated each rising edge:
//   - stall_i = vld_out[i] & ~read_enb[i].
//   - !stall_i: cnt_i <= 0, soft_reset[i] <= 0.
//   - stall_i and cnt_i == TIMEOUT-1: cnt_i <= 0, soft_reset[i] <= 1.
//   - stall_i otherwise: cnt_i <= cnt_i+1, soft_reset[i] <= 0.
//   - Net effect: soft_reset[i] goes high after the TIMEOUT-th consecutive stalled edge and lasts exactly one cycle.
//   - If the stall persists, a further pulse follows every TIMEOUT cycles.
// - A single read_enb[i]=1 cycle restarts the count.
// - The three ports are fully independent; simultaneous timeouts pulse simultaneously.
// - reset asserted mid-packet: addr_reg returns to 11 and all outputs return to reset values immediately.
// - detect_add during write_enb_reg=1: the new address steers writes from the next cycle.
//   - The current cycle still uses the old addr_reg.
// CONFIGURATION
// - ROUTER_SYNC_STICKY_STATUS_EN defined:
//   - Ports timeout_status and status_clr exist.
//   - A soft_reset[i] pulse sets timeout_status[i] on the same edge.
//   - status_clr=1 clears all bits on the next edge.
//   - If a set and status_clr occur on the same edge, set wins for that bit.
// - ROUTER_SYNC_STICKY_STATUS_EN undefined:
//   - Those ports and their logic are absent.
//   - All other behaviour is identical.
// TESTING
// - Reset:
//   - Assert reset with empty=3'b111 -> write_enb=000, fifo_full=0, vld_out=000, soft_reset=000.
// - Steering:
//   - detect_add=1 with data_in=01, then write_enb_reg=1 -> write_enb=010.
//   - With full=010 -> fifo_full=1.
//   - With full=001 -> fifo_full=0.
// - Invalid address:
//   - detect_add with data_in=11, then write_enb_reg=1 -> write_enb=000, fifo_full=0 even with full=111.
// - Timeout:
//   - empty[2]=0, read_enb[2]=0 held -> soft_reset[2] is high for exactly one cycle after the 30th stalled edge.
//   - soft_reset[0] and soft_reset[1] stay 0.
// - Timeout abort:
//   - Stall port 0 for 29 cycles, assert read_enb[0] for 1 cycle, stall again -> no pulse until 30 more stalled edges.
// - Sticky status (macro defined):
//   - After the port-1 timeout, timeout_status=010 holds until status_clr.
//   - A coincident new timeout on port 1 while status_clr=1 keeps bit 1 set.

Source files
------------

// File: rtl/router_sync.sv
// router_sync: latches each packet's destination address, steers the write strobe to one output FIFO, and returns that FIFO's full flag to the FSM.
// Latency: write_enb, fifo_full and vld_out are combinational. soft_reset and timeout_status are registered and change one edge after the condition is seen.
// Backpressure: fifo_full reports the addressed FIFO's full flag. A port that holds valid data without a read for TIMEOUT edges gets a one-cycle soft_reset.
// Optional feature: define ROUTER_SYNC_STICKY_STATUS_EN to add the sticky timeout_status/status_clr ports.
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic [2:0] read_enb,
    input  logic [2:0] empty,
    input  logic [2:0] full,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic [2:0] vld_out,
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    output logic [2:0] timeout_status,
    input  logic       status_clr,
`endif
    output logic [2:0] soft_reset
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       soft_reset_q, soft_reset_d;
    logic [2:0]       stall;

    // Address latch: the header strobe captures the destination. Code 11 is latched too and selects no FIFO.
    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in;
        end
    end

    // Address register. It resets to 11 so that no FIFO is written before a header arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= 2'b11;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Write steering and full-flag mux, both taken from the latched address.
    // A detect_add in the same cycle still uses the old address.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full[0];
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full[1];
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full[2];
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out = ~empty;
    assign stall   = vld_out & ~read_enb;

    // Per-port stall counters. The count restarts on any non-stalled cycle.
    // Reaching TIMEOUT stalled edges fires a single pulse and restarts the count, so a persistent stall pulses periodically.
    always_comb begin
        soft_reset_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (stall[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    logic [2:0] status_q, status_d;

    // Sticky flags. A timeout pulse sets its bit on the same edge the pulse is issued.
    // status_clr clears all bits, but a coincident set keeps its bit.
    always_comb begin
        status_d = status_clr ? 3'b000 : status_q;
        status_d = status_d | soft_reset_d;
    end

    // Status register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q <= 3'b000;
        end else begin
            status_q <= status_d;
        end
    end

    assign timeout_status = status_q;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Testbench for router_sync: directed scenarios with explicit expectations, plus a randomized run checked against a run-length model.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled after inputs settle or 1 unit after the edge.
// Build with ROUTER_SYNC_STICKY_STATUS_EN defined to also exercise the sticky status ports.
module tb_router_sync;

    localparam int TO = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] read_enb, empty, full;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic       fifo_full;
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    logic [2:0] timeout_status;
    logic       status_clr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: length of the current stall run per port, plus the last latched address.
    int         run [3];
    int         m_addr;
    logic [2:0] m_sr;
    logic [2:0] m_status;

    router_sync dut (
        .clock         (clock),
        .reset         (reset),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out       (vld_out),
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        .timeout_status(timeout_status),
        .status_clr    (status_clr),
`endif
        .soft_reset    (soft_reset)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 3; i++) run[i] = 0;
        m_addr   = 3;
        m_sr     = 3'b000;
        m_status = 3'b000;
    endtask

    // One rising edge: the model applies the rules to the inputs present at the edge.
    task automatic tick();
        logic st;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            st = !empty[i] && !read_enb[i];
            run[i]  = st ? run[i] + 1 : 0;
            m_sr[i] = st && (run[i] % TO == 0);
        end
        if (detect_add) m_addr = int'(data_in);
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        if (status_clr) m_status = 3'b000;
        m_status = m_status | m_sr;
`endif
        #1;
    endtask

    task automatic idle_inputs();
        detect_add    = 1'b0;
        data_in       = 2'b00;
        write_enb_reg = 1'b0;
        read_enb      = 3'b000;
        empty         = 3'b111;
        full          = 3'b000;
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        status_clr    = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        write_enb_reg = 1'b1;
        full          = 3'b111;
        reset         = 1'b1;
        model_reset();
        #3;
        n_checks++;
        if (write_enb !== 3'b000) $display("FAIL reset_write_enb: got %b want 000", write_enb);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full: got %b want 0", fifo_full);
        else n_pass++;
        n_checks++;
        if (vld_out !== 3'b000) $display("FAIL reset_vld_out: got %b want 000", vld_out);
        else n_pass++;
        n_checks++;
        if (soft_reset !== 3'b000) $display("FAIL reset_soft_reset: got %b want 000", soft_reset);
        else n_pass++;
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_steering();
        do_reset();
        detect_add = 1'b1;
        data_in    = 2'b01;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b010;
        #1;
        n_checks++;
        if (write_enb !== 3'b010) $display("FAIL steer_write_enb: got %b want 010", write_enb);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b1) $display("FAIL steer_full_hit: got %b want 1", fifo_full);
        else n_pass++;
        full = 3'b001;
        #1;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL steer_full_other: got %b want 0", fifo_full);
        else n_pass++;
        write_enb_reg = 1'b0;
        #1;
        n_checks++;
        if (write_enb !== 3'b000) $display("FAIL steer_no_req: got %b want 000", write_enb);
        else n_pass++;
    endtask

    task automatic test_invalid_addr();
        do_reset();
        detect_add = 1'b1;
        data_in    = 2'b11;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        #1;
        n_checks++;
        if (write_enb !== 3'b000) $display("FAIL invalid_write_enb: got %b want 000", write_enb);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL invalid_fifo_full: got %b want 0", fifo_full);
        else n_pass++;
        write_enb_reg = 1'b0;
    endtask

    // A detect_add during an active write takes effect from the next cycle.
    task automatic test_back_to_back();
        do_reset();
        detect_add = 1'b1;
        data_in    = 2'b00;
        tick();
        write_enb_reg = 1'b1;
        data_in       = 2'b10;
        #1;
        n_checks++;
        if (write_enb !== 3'b001) $display("FAIL b2b_old_addr: got %b want 001", write_enb);
        else n_pass++;
        tick();
        detect_add = 1'b0;
        #1;
        n_checks++;
        if (write_enb !== 3'b100) $display("FAIL b2b_new_addr: got %b want 100", write_enb);
        else n_pass++;
        // A reset in the middle of a packet drops the address at once.
        full  = 3'b100;
        reset = 1'b1;
        #1;
        n_checks++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0)
            $display("FAIL midpkt_reset: got we=%b ff=%b want 000/0", write_enb, fifo_full);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        idle_inputs();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        empty = 3'b011;
        bad   = 0;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            n_checks++;
            if (soft_reset !== ((k == TO) ? 3'b100 : 3'b000)) begin
                $display("FAIL timeout_edge%0d: got %b want %b", k, soft_reset,
                         (k == TO) ? 3'b100 : 3'b000);
                bad++;
            end else n_pass++;
        end
        empty = 3'b111;
    endtask

    task automatic test_timeout_abort();
        do_reset();
        empty = 3'b110;
        for (int k = 1; k <= TO - 1; k++) tick();
        n_checks++;
        if (soft_reset !== 3'b000) $display("FAIL abort_pre: got %b want 000", soft_reset);
        else n_pass++;
        read_enb = 3'b001;
        tick();
        read_enb = 3'b000;
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            n_checks++;
            if (soft_reset !== ((k == TO) ? 3'b001 : 3'b000))
                $display("FAIL abort_edge%0d: got %b want %b", k, soft_reset,
                         (k == TO) ? 3'b001 : 3'b000);
            else n_pass++;
        end
        empty = 3'b111;
    endtask

`ifdef ROUTER_SYNC_STICKY_STATUS_EN
    task automatic test_sticky();
        do_reset();
        empty = 3'b101;
        for (int k = 1; k <= TO; k++) tick();
        n_checks++;
        if (timeout_status !== 3'b010) $display("FAIL sticky_set: got %b want 010", timeout_status);
        else n_pass++;
        for (int k = 1; k <= 3; k++) tick();
        n_checks++;
        if (timeout_status !== 3'b010) $display("FAIL sticky_hold: got %b want 010", timeout_status);
        else n_pass++;
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        n_checks++;
        if (timeout_status !== 3'b000) $display("FAIL sticky_clr: got %b want 000", timeout_status);
        else n_pass++;
        // The stall continues. This is edge 34 of the run, so 25 more edges reach edge 59.
        for (int k = 1; k <= 2 * TO - 1 - (TO + 4); k++) tick();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        n_checks++;
        if (timeout_status !== 3'b010 || soft_reset !== 3'b010)
            $display("FAIL sticky_set_wins: got st=%b sr=%b want 010/010", timeout_status, soft_reset);
        else n_pass++;
        empty = 3'b111;
    endtask
`endif

    task automatic test_random();
        logic [2:0] exp_we;
        logic       exp_ff;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            detect_add    = ($urandom_range(0, 3) == 0);
            data_in       = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            full          = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                empty[i]    = ($urandom_range(0, 9) == 0);
                read_enb[i] = ($urandom_range(0, 15) == 0);
            end
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
            status_clr = ($urandom_range(0, 15) == 0);
`endif
            #1;
            exp_we = (write_enb_reg && m_addr < 3) ? (3'b001 << m_addr) : 3'b000;
            exp_ff = (m_addr < 3) ? full[m_addr] : 1'b0;
            n_checks++;
            if (write_enb !== exp_we || fifo_full !== exp_ff || vld_out !== ~empty)
                $display("FAIL rand_comb%0d: got we=%b ff=%b v=%b want we=%b ff=%b v=%b",
                         c, write_enb, fifo_full, vld_out, exp_we, exp_ff, ~empty);
            else n_pass++;
            tick();
            n_checks++;
            if (soft_reset !== m_sr)
                $display("FAIL rand_soft_reset%0d: got %b want %b", c, soft_reset, m_sr);
            else n_pass++;
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
            n_checks++;
            if (timeout_status !== m_status)
                $display("FAIL rand_status%0d: got %b want %b", c, timeout_status, m_status);
            else n_pass++;
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        test_reset();
        test_steering();
        test_invalid_addr();
        test_back_to_back();
        test_timeout();
        test_timeout_abort();
`ifdef ROUTER_SYNC_STICKY_STATUS_EN
        test_sticky();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
